pwm_generator: RTL and testbench



---
 rtl/pwm_generator.sv | 168 ++++++++++++++++
 tb/tb_pwm_generator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_generator.sv
// Four-channel RC/ESC PWM generator driven by a free-running frame timer.
// Per-channel widths are double-buffered and only applied on a frame boundary.
module pwm_generator #(
    parameter int CLK_PER_US   = 38,
    parameter int PERIOD_US    = 20000,
    parameter int MIN_PULSE_US = 1000,
    parameter int MAX_SPAN_US  = 1000,
    parameter int N_VAL        = 10
) (
    input  logic             sys_clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             load,
    input  logic [N_VAL-1:0] motor_1_val,
    input  logic [N_VAL-1:0] motor_2_val,
    input  logic [N_VAL-1:0] motor_3_val,
    input  logic [N_VAL-1:0] motor_4_val,
    output logic             motor_1_pwm,
    output logic             motor_2_pwm,
    output logic             motor_3_pwm,
    output logic             motor_4_pwm,
    output logic             frame_start,
    output logic             running
);

    // state  | meaning
    // S_IDLE | counters held at 0, outputs low, waiting for enable
    // S_RUN  | frame timer running, one pulse per channel per frame

    localparam int PS_W    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int US_W    = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam int SPAN_W  = (MAX_SPAN_US > 0) ? $clog2(MAX_SPAN_US + 1) : 1;
    localparam int SUM_W   = $clog2(MIN_PULSE_US + MAX_SPAN_US + 1);
    localparam int CMP_W   = ((US_W > SUM_W) ? US_W : SUM_W) + 1;
    localparam int CLP_W   = (N_VAL > SPAN_W) ? N_VAL : SPAN_W;

    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(CLK_PER_US - 1);
    localparam logic [US_W-1:0]   US_LAST   = US_W'(PERIOD_US - 1);
    localparam logic [SPAN_W-1:0] SPAN_MAX  = SPAN_W'(MAX_SPAN_US);
    localparam logic [CMP_W-1:0]  MIN_PULSE = CMP_W'(MIN_PULSE_US);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PS_W-1:0]   r_presc;
    logic [US_W-1:0]   r_us;
    logic              w_run;
    logic              w_us_tick;
    logic              w_frame_end;
    logic              w_boundary;

    logic [N_VAL-1:0]  w_val         [4];
    logic [SPAN_W-1:0] w_val_clamped [4];
    logic [SPAN_W-1:0] r_shadow      [4];
    logic [SPAN_W-1:0] r_active      [4];
    logic [SPAN_W-1:0] w_width       [4];
    logic [3:0]        r_pwm;
    logic [3:0]        w_pwm_nxt;

    function automatic logic [SPAN_W-1:0] clamp_span(input logic [N_VAL-1:0] v);
        logic [CLP_W-1:0] v_ext;
        v_ext = CLP_W'(v);
        if (v_ext > CLP_W'(MAX_SPAN_US)) begin
            return SPAN_MAX;
        end
        return SPAN_W'(v);
    endfunction

    assign w_val[0] = motor_1_val;
    assign w_val[1] = motor_2_val;
    assign w_val[2] = motor_3_val;
    assign w_val[3] = motor_4_val;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_val_clamped[i] = clamp_span(w_val[i]);
        end
    end

    assign w_run       = (r_state == S_RUN);
    assign w_us_tick   = w_run && (r_presc == PS_LAST);
    assign w_frame_end = w_us_tick && (r_us == US_LAST);
    assign w_boundary  = w_run && (r_presc == '0) && (r_us == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (enable) w_state_nxt = S_RUN;
            S_RUN:  if (w_frame_end && !enable) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters wrap to 0 on the last tick of a frame, so leaving RUN there
    // already leaves them at 0 for the next IDLE->RUN boundary.
    always_ff @(posedge sys_clk) begin
        if (!resetn || !w_run) begin
            r_presc <= '0;
            r_us    <= '0;
        end else begin
            if (w_us_tick) begin
                r_presc <= '0;
                r_us    <= w_frame_end ? '0 : r_us + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= w_val_clamped[i];
            end
        end
    end

    // A load on the boundary cycle bypasses the shadow so it hits this frame.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_width[i] = r_active[i];
            if (w_boundary) begin
                w_width[i] = load ? w_val_clamped[i] : r_shadow[i];
            end
            w_pwm_nxt[i] = w_run &&
                           (CMP_W'(r_us) < (MIN_PULSE + CMP_W'(w_width[i])));
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                r_active[i] <= '0;
            end
            r_pwm <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_active[i] <= w_width[i];
            end
            r_pwm <= w_pwm_nxt;
        end
    end

    assign motor_1_pwm = r_pwm[0];
    assign motor_2_pwm = r_pwm[1];
    assign motor_3_pwm = r_pwm[2];
    assign motor_4_pwm = r_pwm[3];
    assign frame_start = w_boundary;
    assign running     = w_run;

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: per-cycle comparison against a frame-time model,
// plus table-driven per-frame pulse-width and period measurements.
module tb_pwm_generator;

    localparam int CLK_PER_US   = 2;
    localparam int PERIOD_US    = 3000;
    localparam int MIN_PULSE_US = 1000;
    localparam int MAX_SPAN_US  = 1000;
    localparam int N_VAL        = 10;
    localparam int FRAME        = CLK_PER_US * PERIOD_US;

    typedef struct {
        logic [3:0][N_VAL-1:0] vals;
        logic [3:0][15:0]      widths;
    } frame_vec_t;

    logic             sys_clk = 1'b0;
    logic             resetn;
    logic             enable;
    logic             load;
    logic [N_VAL-1:0] motor_1_val, motor_2_val, motor_3_val, motor_4_val;
    logic             motor_1_pwm, motor_2_pwm, motor_3_pwm, motor_4_pwm;
    logic             frame_start;
    logic             running;
    logic [3:0]       w_pwm_v;

    int n_vec = 0;
    int n_bad = 0;
    int n_cyc = 0;

    // Model: position in the frame counted in clock cycles, 0 = boundary cycle.
    bit m_run = 1'b0;
    int m_t = 0;
    int m_shadow [4];
    int m_active [4];
    bit m_pwm    [4];

    always #5 sys_clk = ~sys_clk;

    assign w_pwm_v = {motor_4_pwm, motor_3_pwm, motor_2_pwm, motor_1_pwm};

    pwm_generator #(
        .CLK_PER_US   (CLK_PER_US),
        .PERIOD_US    (PERIOD_US),
        .MIN_PULSE_US (MIN_PULSE_US),
        .MAX_SPAN_US  (MAX_SPAN_US),
        .N_VAL        (N_VAL)
    ) dut (
        .sys_clk     (sys_clk),
        .resetn      (resetn),
        .enable      (enable),
        .load        (load),
        .motor_1_val (motor_1_val),
        .motor_2_val (motor_2_val),
        .motor_3_val (motor_3_val),
        .motor_4_val (motor_4_val),
        .motor_1_pwm (motor_1_pwm),
        .motor_2_pwm (motor_2_pwm),
        .motor_3_pwm (motor_3_pwm),
        .motor_4_pwm (motor_4_pwm),
        .frame_start (frame_start),
        .running     (running)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, n_cyc);
        end
    endtask

    task automatic drive_vals(input logic [3:0][N_VAL-1:0] v);
        motor_1_val = v[0];
        motor_2_val = v[1];
        motor_3_val = v[2];
        motor_4_val = v[3];
    endtask

    task automatic drive_random_vals();
        drive_vals({N_VAL'($urandom), N_VAL'($urandom), N_VAL'($urandom), N_VAL'($urandom)});
    endtask

    // Advance one clock: predict the post-edge outputs, clock, then compare.
    task automatic cyc();
        logic [3:0][N_VAL-1:0] v;
        int   lv [4];
        logic [5:0] exp_o;
        logic [5:0] act_o;
        v = {motor_4_val, motor_3_val, motor_2_val, motor_1_val};
        for (int i = 0; i < 4; i++) begin
            lv[i] = (int'(v[i]) > MAX_SPAN_US) ? MAX_SPAN_US : int'(v[i]);
        end
        if (!resetn) begin
            m_run = 1'b0;
            m_t   = 0;
            for (int i = 0; i < 4; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
                m_pwm[i]    = 1'b0;
            end
        end else begin
            if (m_run) begin
                if (m_t == 0) begin
                    for (int i = 0; i < 4; i++) m_active[i] = load ? lv[i] : m_shadow[i];
                end
                for (int i = 0; i < 4; i++) begin
                    m_pwm[i] = ((m_t + 1) <= (MIN_PULSE_US + m_active[i]) * CLK_PER_US);
                end
                if (m_t == FRAME - 1) begin
                    m_t   = 0;
                    m_run = enable;
                end else begin
                    m_t++;
                end
            end else begin
                for (int i = 0; i < 4; i++) m_pwm[i] = 1'b0;
                if (enable) begin
                    m_run = 1'b1;
                    m_t   = 0;
                end
            end
            if (load) begin
                for (int i = 0; i < 4; i++) m_shadow[i] = lv[i];
            end
        end
        @(posedge sys_clk);
        #1;
        n_cyc++;
        exp_o = {m_run && (m_t == 0), m_run, m_pwm[3], m_pwm[2], m_pwm[1], m_pwm[0]};
        act_o = {frame_start, running, w_pwm_v};
        n_vec++;
        if (act_o !== exp_o) begin
            n_bad++;
            $display("FAIL cycle_model t=%0d cycle %0d: fs/run/pwm4..1 got %b expected %b",
                     m_t, n_cyc, act_o, exp_o);
        end
    endtask

    // Called while the boundary cycle is being observed; runs one frame and
    // checks pulse widths and where the next frame_start lands.
    task automatic run_frame(input string name, input logic [3:0][N_VAL-1:0] ld_vals,
                             input int ld_at, input int en_off_at,
                             input logic [3:0][15:0] exp_w, input int exp_next_fs);
        int hi [4];
        int fs_seen;
        for (int i = 0; i < 4; i++) hi[i] = 0;
        fs_seen = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (c == ld_at) begin
                load = 1'b1;
                drive_vals(ld_vals);
            end else begin
                load = 1'b0;
                drive_random_vals();
            end
            if (c == en_off_at) enable = 1'b0;
            cyc();
            for (int i = 0; i < 4; i++) hi[i] += int'(w_pwm_v[i]);
            fs_seen += int'(frame_start);
        end
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_width_ch%0d", name, i + 1), hi[i], int'(exp_w[i]));
        end
        chk($sformatf("%s_fs_count", name), fs_seen, exp_next_fs);
        chk($sformatf("%s_fs_at_period", name), int'(frame_start), exp_next_fs);
    endtask

    initial begin
        frame_vec_t tbl [3];
        logic [3:0][N_VAL-1:0] nxt;
        logic [3:0][N_VAL-1:0] bnd_vals;
        logic [3:0][15:0]      w_default;
        logic [3:0][15:0]      w_bnd;
        int idle_hi;

        // Channel order inside each packed vector is {ch4, ch3, ch2, ch1}.
        tbl[0].vals   = {10'd1000, 10'd500, 10'd250, 10'd0};
        tbl[0].widths = {16'd4000, 16'd3000, 16'd2500, 16'd2000};
        tbl[1].vals   = {10'd1, 10'd999, 10'd1001, 10'd1023};
        tbl[1].widths = {16'd2002, 16'd3998, 16'd4000, 16'd4000};
        tbl[2].vals   = {10'd768, 10'd512, 10'd0, 10'd1000};
        tbl[2].widths = {16'd3536, 16'd3024, 16'd2000, 16'd4000};
        bnd_vals      = {10'd400, 10'd300, 10'd200, 10'd100};
        w_bnd         = {16'd2800, 16'd2600, 16'd2400, 16'd2200};
        w_default     = {16'd2000, 16'd2000, 16'd2000, 16'd2000};

        resetn = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        drive_vals('0);
        repeat (3) cyc();
        chk("reset_outputs", int'({frame_start, running, w_pwm_v}), 0);

        resetn = 1'b1;
        enable = 1'b1;
        cyc();
        chk("first_frame_start", int'(frame_start), 1);
        chk("first_running", int'(running), 1);

        // Mid-pulse load: current frame keeps default widths.
        run_frame("frame0", tbl[0].vals, 500, -1, w_default, 1);

        for (int k = 0; k < 3; k++) begin
            nxt = (k < 2) ? tbl[k + 1].vals : tbl[k].vals;
            run_frame($sformatf("tbl%0d", k), nxt, (k < 2) ? 700 + 1500 * k : -1, -1,
                      tbl[k].widths, 1);
        end

        run_frame("bnd_load", bnd_vals, 0, -1, w_bnd, 1);

        // Disable at us 500: frame completes, then IDLE.
        run_frame("disable", bnd_vals, -1, 1000, w_bnd, 0);
        chk("disable_running", int'(running), 0);

        idle_hi = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 10) begin
                load = 1'b1;
                drive_vals(tbl[1].vals);
            end else begin
                load = 1'b0;
                drive_random_vals();
            end
            cyc();
            idle_hi += int'(w_pwm_v != 4'b0) + int'(running) + int'(frame_start);
        end
        load = 1'b0;
        chk("idle_quiet", idle_hi, 0);

        enable = 1'b1;
        cyc();
        chk("reenable_fs", int'(frame_start), 1);
        run_frame("reenable", tbl[1].vals, -1, -1, tbl[1].widths, 1);

        for (int c = 0; c < 2 * FRAME; c++) begin
            drive_random_vals();
            load = ($urandom_range(0, 399) == 0);
            cyc();
        end
        load = 1'b0;

        for (int c = 0; c < 300; c++) begin
            drive_random_vals();
            cyc();
        end
        resetn = 1'b0;
        cyc();
        chk("reset_midpulse", int'({frame_start, running, w_pwm_v}), 0);
        resetn = 1'b1;
        cyc();
        chk("post_reset_fs", int'(frame_start), 1);
        run_frame("post_reset", tbl[0].vals, -1, -1, w_default, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
